// File: rtl/yuv_sched_pkg.sv
// yuv_sched_pkg: shared widths and FSM encoding for the YUV stream scheduler.
package yuv_sched_pkg;
  localparam int BEAT_W = 32;
  localparam int WORD_W = 64;
  typedef enum logic [2:0] {IDLE, WAIT_FRAME, ACTIVE, LINE_GAP, FRAME_END} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO with flush.
// A flush in the same cycle as a write leaves exactly that one word stored.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr, w_wr_base;
  assign w_wr_base = flush_i ? '0 : r_wr_ptr;
  always_ff @(posedge clk_i)
    if (wr_en_i) r_mem[w_wr_base[AW-1:0]] <= wr_data_i;
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_base + (AW+1)'(wr_en_i);
      r_rd_ptr <= flush_i ? '0 : r_rd_ptr + (AW+1)'(rd_en_i);
    end
  assign rd_data_o = r_mem[r_rd_ptr[AW-1:0]];
  assign empty_o   = r_wr_ptr == r_rd_ptr;
  assign full_o    = r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]};
endmodule

// File: rtl/yuv_stream_scheduler.sv
// yuv_stream_scheduler: buffers 64-bit YUV words and emits them as 32-bit beats
// framed into lines and frames for a USB parallel sink.
module yuv_stream_scheduler
  import yuv_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic [11:0]       line_words_i,
  input  logic [11:0]       lines_i,
  input  logic              frame_start_i,
  input  logic [WORD_W-1:0] yuv_i,
  input  logic              yuv_valid_i,
  output logic [BEAT_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              ready_i,
  output logic              frame_valid_o,
  output logic              line_valid_o,
  output logic              overflow_o,
  output logic [15:0]       frame_count_o
);
  state_t r_state, w_next;
  logic [11:0] r_line_words, r_lines, r_line_cnt;
  logic [12:0] r_beat_cnt;
  logic [15:0] r_gap_cnt, r_frame_cnt;
  logic [BEAT_W-1:0] r_data;
  logic r_valid, r_sel, r_ovf;
  logic [WORD_W-1:0] w_head;
  logic w_start, w_run, w_xfer, w_last_beat, w_last_line, w_gap_done;
  logic w_can_load, w_empty, w_full, w_wr, w_rd, w_flush;
  assign w_start     = r_state == WAIT_FRAME && enable_i && frame_start_i;
  assign w_run       = r_state == ACTIVE || r_state == LINE_GAP;
  assign w_xfer      = r_valid && ready_i;
  assign w_last_beat = w_xfer && r_beat_cnt == {r_line_words, 1'b0} - 13'd1;
  assign w_last_line = r_line_cnt == r_lines - 12'd1;
  assign w_gap_done  = r_gap_cnt == 16'(GAP_CYCLES - 1);
  // The output register refills only while the line still owes beats.
  assign w_can_load  = r_state == ACTIVE && (!r_valid || w_xfer) && !w_last_beat;
  assign w_rd        = w_can_load && !w_empty && r_sel;
  assign w_wr        = yuv_valid_i && (w_start || (w_run && (!w_full || w_rd)));
  assign w_flush     = w_start || r_state == FRAME_END;
  sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(w_flush), .wr_en_i(w_wr),
    .wr_data_i(yuv_i), .rd_en_i(w_rd), .rd_data_o(w_head), .full_o(w_full), .empty_o(w_empty)
  );
  always_ff @(posedge clk_i)
    r_state <= !reset_n_i ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = enable_i ? WAIT_FRAME : IDLE;
      WAIT_FRAME: w_next = !enable_i ? IDLE : frame_start_i ? ACTIVE : WAIT_FRAME;
      ACTIVE:     w_next = !w_last_beat ? ACTIVE : w_last_line ? FRAME_END : LINE_GAP;
      LINE_GAP:   w_next = w_gap_done ? ACTIVE : LINE_GAP;
      FRAME_END:  w_next = enable_i ? WAIT_FRAME : IDLE;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      r_line_words <= 12'd1;
      r_lines      <= 12'd1;
      r_line_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_frame_cnt  <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sel        <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_start) begin
        r_line_words <= line_words_i == 12'd0 ? 12'd1 : line_words_i;
        r_lines      <= lines_i == 12'd0 ? 12'd1 : lines_i;
        r_line_cnt   <= '0;
        r_beat_cnt   <= '0;
        r_sel        <= 1'b0;
      end
      if (w_xfer) r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 13'd1;
      if (w_last_beat) r_line_cnt <= r_line_cnt + 12'd1;
      r_gap_cnt <= r_state == LINE_GAP ? r_gap_cnt + 16'd1 : '0;
      if (w_can_load) begin
        r_valid <= !w_empty;
        if (!w_empty) begin
          r_data <= r_sel ? w_head[BEAT_W-1:0] : w_head[WORD_W-1:BEAT_W];
          r_sel  <= ~r_sel;
        end
      end else if (w_xfer) r_valid <= 1'b0;
      if (yuv_valid_i && w_run && !w_wr) r_ovf <= 1'b1;
      if (r_state == FRAME_END) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  assign data_o        = r_data;
  assign data_valid_o  = r_valid;
  assign frame_valid_o = w_run;
  assign line_valid_o  = r_state == ACTIVE;
  assign overflow_o    = r_ovf;
  assign frame_count_o = r_frame_cnt;
endmodule
